tty_writer: RTL and testbench

TTY_WRITER -- requirements
Module: tty_writer

---
 rtl/tty_pkg.sv | 30 +++
 rtl/tty_writer.sv | 141 ++++++++++++++
 tb/tb_tty_writer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tty_pkg.sv
// Shared types and constants for the text-terminal screen writer.
// TTY_ESC_COLOR_EN adds the ESC state used to load a new colour attribute.
package tty_pkg;

   localparam int ROW_W = 6;
   localparam int COL_W = 7;
   localparam int ADR_W = ROW_W + COL_W;

   localparam logic [7:0] CHR_BS    = 8'h08;
   localparam logic [7:0] CHR_LF    = 8'h0A;
   localparam logic [7:0] CHR_FF    = 8'h0C;
   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_ESC   = 8'h1B;
   localparam logic [7:0] CHR_SPACE = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      CLR_LINE,
      CLR_ALL
`ifdef TTY_ESC_COLOR_EN
      , ESC
`endif
   } tty_state_e;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/tty_writer.sv
// Byte-stream to character-cell screen writer with cursor, line/screen clear.
// Define TTY_ESC_COLOR_EN to let ESC <attr> change the colour attribute.
module tty_writer
   import tty_pkg::*;
#(
   parameter int         COLS     = 90,
   parameter int         ROWS     = 56,
   parameter logic [7:0] DEF_ATTR = 8'h07
) (
   input  logic             pixel_clock,
   input  logic             reset,
   input  logic [7:0]       char_data,
   input  logic             char_valid,
   output logic             char_ready,
   output logic [15:0]      wrdata,
   output logic [ADR_W-1:0] wradr,
   output logic             wren
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   tty_state_e       state;
   logic [ROW_W-1:0] cur_row;
   logic [COL_W-1:0] cur_col;
   logic [7:0]       attr;
   logic [ADR_W-1:0] clr_cnt;

   logic [ROW_W-1:0] next_row;
   logic [COL_W-1:0] col_dec;
   logic             accept;

`ifdef TTY_ESC_COLOR_EN
   assign char_ready = (state == IDLE) || (state == ESC);
`else
   assign char_ready = (state == IDLE);
`endif

   assign accept   = char_valid && char_ready;
   assign next_row = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
   assign col_dec  = cur_col - COL_W'(1);

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state   <= CLR_ALL;
         clr_cnt <= '0;
         cur_row <= '0;
         cur_col <= '0;
         attr    <= DEF_ATTR;
         wren    <= 1'b0;
         wradr   <= '0;
         wrdata  <= '0;
      end else begin
         wren <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_printable(char_data)) begin
                     wren   <= 1'b1;
                     wradr  <= {cur_row, cur_col};
                     wrdata <= {attr, char_data};
                     state  <= WRITE;
                  end else begin
                     case (char_data)
                        CHR_CR: cur_col <= '0;
                        CHR_LF: begin
                           cur_row <= next_row;
                           clr_cnt <= '0;
                           state   <= CLR_LINE;
                        end
                        CHR_BS: begin
                           if (cur_col != '0) begin
                              cur_col <= col_dec;
                              wren    <= 1'b1;
                              wradr   <= {cur_row, col_dec};
                              wrdata  <= {attr, CHR_SPACE};
                           end
                        end
                        CHR_FF: begin
                           clr_cnt <= '0;
                           state   <= CLR_ALL;
                        end
`ifdef TTY_ESC_COLOR_EN
                        CHR_ESC: state <= ESC;
`endif
                        default: ;
                     endcase
                  end
               end
            end
            // Cursor advance after a printable write; last column wraps into a line feed.
            WRITE: begin
               if (cur_col == LAST_COL) begin
                  cur_col <= '0;
                  cur_row <= next_row;
                  clr_cnt <= '0;
                  state   <= CLR_LINE;
               end else begin
                  cur_col <= cur_col + COL_W'(1);
                  state   <= IDLE;
               end
            end
            CLR_LINE: begin
               wren   <= 1'b1;
               wradr  <= {cur_row, clr_cnt[COL_W-1:0]};
               wrdata <= {attr, CHR_SPACE};
               if (clr_cnt[COL_W-1:0] == LAST_COL) begin
                  clr_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  clr_cnt <= clr_cnt + ADR_W'(1);
               end
            end
            // Sweeps the full address space, including the invisible columns.
            CLR_ALL: begin
               wren   <= 1'b1;
               wradr  <= clr_cnt;
               wrdata <= {attr, CHR_SPACE};
               if (&clr_cnt) begin
                  clr_cnt <= '0;
                  cur_row <= '0;
                  cur_col <= '0;
                  state   <= IDLE;
               end else begin
                  clr_cnt <= clr_cnt + ADR_W'(1);
               end
            end
`ifdef TTY_ESC_COLOR_EN
            ESC: begin
               if (accept) begin
                  attr  <= char_data;
                  state <= IDLE;
               end
            end
`endif
            default: state <= CLR_ALL;
         endcase
      end
   end

endmodule

// File: tb/tb_tty_writer.sv
// Randomised bench for tty_writer: a screen-level model predicts every write.
module tb_tty_writer;

   localparam int COLS = 90;
   localparam int ROWS = 56;
   localparam logic [7:0] DEF_ATTR = 8'h07;
`ifdef TTY_ESC_COLOR_EN
   localparam bit ESC_EN = 1'b1;
`else
   localparam bit ESC_EN = 1'b0;
`endif

   logic        pixel_clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  char_data = 8'h00;
   logic        char_valid = 1'b0;
   logic        char_ready;
   logic [15:0] wrdata;
   logic [12:0] wradr;
   logic        wren;

   tty_writer #(.COLS(COLS), .ROWS(ROWS), .DEF_ATTR(DEF_ATTR)) dut (
      .pixel_clock(pixel_clock),
      .reset      (reset),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .wrdata     (wrdata),
      .wradr      (wradr),
      .wren       (wren)
   );

   always #5 pixel_clock = ~pixel_clock;

   int n_chk  = 0;
   int n_fail = 0;
   int wr_count = 0;
   logic [28:0] exp_q[$];

   int m_row, m_col;
   logic [7:0] m_attr;
   bit m_esc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every write the DUT makes must be the next one the model predicted.
   always @(negedge pixel_clock) begin
      if (!reset && wren) begin
         wr_count++;
         if (exp_q.size() == 0) check("spurious_wren", 32'(wren), 32'd0);
         else begin
            logic [28:0] e;
            e = exp_q.pop_front();
            check("wradr", 32'(wradr), 32'(e[28:16]));
            check("wrdata", 32'(wrdata), 32'(e[15:0]));
         end
      end
   end

   function automatic void push(input int row, input int col, input logic [7:0] ch);
      exp_q.push_back({13'(row * 128 + col), m_attr, ch});
   endfunction

   function automatic void push_clear_all();
      for (int a = 0; a < 8192; a++) exp_q.push_back({13'(a), m_attr, 8'h20});
   endfunction

   function automatic void model_lf();
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      for (int c = 0; c < COLS; c++) push(m_row, c, 8'h20);
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      if (m_esc) begin
         m_attr = b;
         m_esc = 1'b0;
      end else if (b >= 8'h20 && b <= 8'h7E) begin
         push(m_row, m_col, b);
         if (m_col == COLS - 1) begin
            m_col = 0;
            model_lf();
         end else m_col++;
      end else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h0A) model_lf();
      else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
            push(m_row, m_col, 8'h20);
         end
      end else if (b == 8'h0C) begin
         push_clear_all();
         m_row = 0;
         m_col = 0;
      end else if (b == 8'h1B && ESC_EN) m_esc = 1'b1;
   endfunction

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge pixel_clock);
      while (!char_ready && n < 20000) begin
         @(negedge pixel_clock);
         n++;
      end
      if (!char_ready) check("ready_timeout", 32'(char_ready), 32'd1);
      char_data  = b;
      char_valid = 1'b1;
      model_byte(b);
      @(posedge pixel_clock);
      #1 char_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge pixel_clock);
         n++;
      end while (!(char_ready && exp_q.size() == 0) && n < 20000);
      if (n >= 20000) begin
         check("idle_timeout_ready", 32'(char_ready), 32'd1);
         check("idle_timeout_queue", 32'(exp_q.size()), 32'd0);
      end
      @(negedge pixel_clock);
   endtask

   task automatic do_reset();
      int base;
      @(negedge pixel_clock);
      reset = 1'b1;
      repeat (2) @(negedge pixel_clock);
      check("rst_wren", 32'(wren), 32'd0);
      check("rst_wradr", 32'(wradr), 32'd0);
      check("rst_wrdata", 32'(wrdata), 32'd0);
      check("rst_ready", 32'(char_ready), 32'd0);
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      m_attr = DEF_ATTR;
      m_esc = 1'b0;
      push_clear_all();
      base = wr_count;
      reset = 1'b0;
      wait_idle();
      check("rst_clear_count", 32'(wr_count - base), 32'd8192);
      check("rst_ready_after", 32'(char_ready), 32'd1);
   endtask

   initial begin
      int base;
      logic [7:0] b;
      int r;

      do_reset();

      // 'A' at home: one cycle after acceptance the cell write appears
      send(8'h41);
      @(negedge pixel_clock);
      check("A_wren", 32'(wren), 32'd1);
      check("A_wradr", 32'(wradr), 32'd0);
      check("A_wrdata", 32'(wrdata), 32'h0741);
      wait_idle();

      // full line of text wraps into row 1 after clearing it
      send(8'h0D);
      for (int i = 0; i < COLS; i++) send(8'(8'h21 + (i % 90)));
      send(8'h42);
      @(negedge pixel_clock);
      check("B_wradr", 32'(wradr), 32'h0080);
      check("B_wren", 32'(wren), 32'd1);
      wait_idle();

      // walk to the last row, then LF wraps to row 0
      while (m_row != ROWS - 1) send(8'h0A);
      wait_idle();
      send(8'h0A);
      wait_idle();
      send(8'h0D);
      send(8'h78);
      @(negedge pixel_clock);
      check("wrap_wradr", 32'(wradr), 32'h0000);
      wait_idle();

      // BS at column 0 does nothing; at column 5 blanks column 4
      send(8'h0D);
      base = wr_count;
      send(8'h08);
      repeat (5) @(negedge pixel_clock);
      check("bs_col0_writes", 32'(wr_count - base), 32'd0);
      for (int i = 0; i < 5; i++) send(8'h61);
      wait_idle();
      send(8'h08);
      @(negedge pixel_clock);
      check("bs_wren", 32'(wren), 32'd1);
      check("bs_wradr", 32'(wradr), 32'h0004);
      check("bs_wrdata", 32'(wrdata), 32'h0720);
      wait_idle();

      // colour escape
      send(8'h1B);
      send(8'h21);
      send(8'h43);
      @(negedge pixel_clock);
      check("esc_wrdata", 32'(wrdata), ESC_EN ? 32'h2143 : 32'h0743);
      wait_idle();

      // randomised byte stream
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(99));
         if (r < 70)      b = 8'($urandom_range(8'h7E, 8'h20));
         else if (r < 77) b = 8'h0A;
         else if (r < 82) b = 8'h0D;
         else if (r < 90) b = 8'h08;
         else if (r < 94) b = 8'h1B;
         else if (r < 97) b = 8'($urandom_range(8'h1F, 8'h10));
         else             b = 8'($urandom_range(8'hFF, 8'h7F));
         send(b);
      end
      if (m_esc) send(8'h07);
      wait_idle();

      // reset in the middle of a line clear restarts the screen clear
      send(8'h0A);
      repeat (10) @(negedge pixel_clock);
      do_reset();

      // form feed clears everything and homes the cursor
      send(8'h33);
      send(8'h0C);
      wait_idle();
      send(8'h5A);
      @(negedge pixel_clock);
      check("ff_home_wradr", 32'(wradr), 32'h0000);
      check("ff_home_wrdata", 32'(wrdata), 32'({m_attr, 8'h5A}));
      wait_idle();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
